pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline controller for the five-stage core. It generates per-stage Stall/Flush for the IF, ID, EX and MEM pipeline registers and owns the exception and control-register state. It watches the MEM-stage register outputs (MemPC, MemEn, MemCtrlOp, MemDstAddr, MemExpCode, MemOut) to retire exceptions, interrupts, ERET and control-register writes. It supplies the redirect PC to the fetch stage.

## Interface
Parameters:
- WORD_ADDR_W, 30, word-address width of PCs
- WORD_DATA_W, 32, data width
- VEC_RESET, 30'h0, reset value of the EXP_VECTOR control register

Ports:
- clk  in  1  single core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset (sampled on clk rising edge only)
- IFBusy, MemBusy  in  1 each  bus-wait stall requests
- LoadHazard  in  1  load-use hazard detected in ID
- IRQ  in  1  level-sensitive external interrupt
- MemPC  in  WORD_ADDR_W  PC of MEM-stage instruction
- MemEn  in  1  MEM-stage instruction valid
- MemCtrlOp  in  2  NOP / WRCR / ERET
- MemDstAddr  in  5  control-register index, low 2 bits used
- MemExpCode  in  3  exception code from MEM register
- MemOut  in  WORD_DATA_W  write data for WRCR
- CRAddr  in  2  control-register read index
- CRData  out  WORD_DATA_W  combinational read data
- IFStall, IDStall, EXStall, MemStall  out  1 each  stage hold
- IFFlush, IDFlush, EXFlush, MemFlush  out  1 each  stage bubble
- PCLoad  out  1  fetch takes NewPC
- NewPC  out  WORD_ADDR_W  redirect target
- GPRKill  out  1  suppress writeback of the current MEM-stage instruction

## Operation
- Control registers, with reset values:
  - 0 STATUS {30'b0, PIE, IE}: 0
  - 1 CAUSE {29'b0, code}: 0
  - 2 EPC {PC, 2'b00}: 0
  - 3 EXP_VECTOR {vec, 2'b00}: VEC_RESET
- Events are evaluated combinationally each cycle. Only the highest-priority event applies:
  1. Busy = IFBusy | MemBusy. All four Stall outputs are 1. No flush, no PCLoad, no state update.
  2. Exception: MemEn & MemExpCode != NO_EXP.
  3. Interrupt: MemEn & IRQ & IE & state==RUN. The code is EXP_EXT_INT.
  4. ERET: MemEn & MemCtrlOp==ERET.
  5. WRCR: MemEn & MemCtrlOp==WRCR. Write MemOut into CR[MemDstAddr[1:0]]. No pipeline effect.
  6. LoadHazard: IFStall=IDStall=1, EXFlush=1.
- Exception or interrupt response:
  - All four Flush outputs are 1; PCLoad=1; NewPC=EXP_VECTOR[31:2]; GPRKill=1.
  - At the edge: EPC<=MemPC, CAUSE<=code, PIE<=IE, IE<=0.
  - FSM goes to REDIRECT.
- ERET response:
  - All four Flush outputs are 1; PCLoad=1; NewPC=EPC[31:2].
  - At the edge: IE<=PIE.
  - FSM goes to REDIRECT.
- FSM states: RUN and REDIRECT.
  - REDIRECT lasts one cycle, during which the interrupt condition is masked.
  - REDIRECT always returns to RUN, unless Busy holds it in REDIRECT.
- WRCR to STATUS or EPC in the same cycle as an exception is discarded, because the exception wins.
- Reserved CR bits read as 0; writes to reserved bits are ignored.
- When no event applies, all outputs are 0 and NewPC=0.

## Timing
- Reset: state RUN and all CRs take their reset values, at the first rising edge with reset=1. Reset asserted mid-redirect discards the pending REDIRECT.
- All Stall, Flush, PCLoad, NewPC and GPRKill outputs are combinational from the current inputs and state. Registered state follows:
  - Cycle t: event visible on Mem* inputs; flush, PCLoad and GPRKill are asserted in cycle t.
  - Edge t→t+1: CR update and FSM transition; the fetch stage loads NewPC.
  - Cycle t+1: REDIRECT, IRQ ignored.
  - Cycle t+2: RUN.
- Busy coincident with an exception: the exception is held off until Busy drops. The MEM register holds its value under MemStall, so the event is retried.
- IRQ and an exception in the same cycle: the exception is taken. IRQ is re-evaluated after REDIRECT, now blocked by IE=0.
- Back-to-back exceptions (one in REDIRECT) are still taken. REDIRECT masks only IRQ.
- CRData reflects a write from the following cycle onward; there is no write-through bypass.

## Structure
- Add to the shared cpu/isa package:
  - CR index constants: CR_STATUS, CR_CAUSE, CR_EPC, CR_VECTOR.
  - CTRL_OP_ERET and CTRL_OP_WRCR codes.
  - EXP_EXT_INT code.
  - FSM state encoding: CTRL_ST_RUN, CTRL_ST_REDIRECT.
- One sub-module: pipe_ctrl_cr, the control-register file (four registers, one write port, one read port, plus exception/ERET update inputs).
- The event priority encoder and the FSM stay in pipe_ctrl.

## Test plan
- Reset: hold reset=1 for 2 cycles, then CRAddr=0..3 → 0, 0, 0, VEC_RESET. All outputs 0.
- Miss-align: MemEn=1, MemExpCode=MISS_ALIGN, MemPC=30'h40, vector=32'h100. Cycle t: all Flush=1, PCLoad=1, NewPC=30'h40, GPRKill=1. After the edge: EPC=32'h100, CAUSE=MISS_ALIGN, IE=0.
- Interrupt with IE=1, then ERET:
  - IRQ=1, MemEn=1, MemPC=30'h20 → EPC=32'h80, CAUSE=EXP_EXT_INT, REDIRECT for 1 cycle.
  - A later ERET → NewPC=30'h20 and IE restored to 1.
- Busy plus exception: MemBusy=1 with an exception pending for 3 cycles → all Stall=1 and no Flush. When MemBusy drops, the exception is taken in that cycle.
- WRCR then LoadHazard:
  - WRCR to CR 3 with MemOut=32'h200 → vector=32'h200 read the next cycle.
  - LoadHazard=1 alone → IFStall=IDStall=EXFlush=1, other outputs 0.
- Reset mid-operation: reset=1 in the REDIRECT cycle → RUN and CRs reset at that edge. The next IRQ is ignored because IE=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: CR indices, control ops, exception codes, FSM states.
package pipe_ctrl_pkg;

  localparam logic [1:0] CR_STATUS = 2'd0;
  localparam logic [1:0] CR_CAUSE  = 2'd1;
  localparam logic [1:0] CR_EPC    = 2'd2;
  localparam logic [1:0] CR_VECTOR = 2'd3;

  localparam logic [1:0] CTRL_OP_WRCR = 2'd1;
  localparam logic [1:0] CTRL_OP_ERET = 2'd2;

  localparam logic [2:0] EXP_NO_EXP  = 3'd0;
  localparam logic [2:0] EXP_EXT_INT = 3'd1;

  typedef enum logic {
    CTRL_ST_RUN      = 1'b0,
    CTRL_ST_REDIRECT = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic pie;
    logic ie;
  } status_t;

endpackage

// File: rtl/pipe_ctrl_cr.sv
// Control-register file: STATUS, CAUSE, EPC, EXP_VECTOR with one write port and one read port.
// Latency: writes and exception/ERET updates land at the next edge; read is combinational, no bypass.
// Backpressure: none; the caller only asserts an update when it is actually retired.
module pipe_ctrl_cr
  import pipe_ctrl_pkg::*;
#(
  parameter int WORD_ADDR_W = 30,
  parameter int WORD_DATA_W = 32,
  parameter logic [WORD_ADDR_W-1:0] VEC_RESET = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [1:0]             wr_addr,
  input  logic [WORD_DATA_W-1:0] wr_data,
  input  logic                   exp_take,
  input  logic [2:0]             exp_code,
  input  logic [WORD_ADDR_W-1:0] exp_pc,
  input  logic                   eret_take,
  input  logic [1:0]             rd_addr,
  output logic [WORD_DATA_W-1:0] rd_data,
  output logic                   ie,
  output logic [WORD_ADDR_W-1:0] epc,
  output logic [WORD_ADDR_W-1:0] vector
);

  status_t    status;
  logic [2:0] cause;

  assign ie = status.ie;

  // Update sources are mutually exclusive by the caller's priority encoding.
  always_ff @(posedge clk) begin
    if (reset) begin
      status <= '0;
      cause  <= EXP_NO_EXP;
      epc    <= '0;
      vector <= VEC_RESET;
    end else if (exp_take) begin
      epc        <= exp_pc;
      cause      <= exp_code;
      status.pie <= status.ie;
      status.ie  <= 1'b0;
    end else if (eret_take) begin
      status.ie <= status.pie;
    end else if (wr_en) begin
      case (wr_addr)
        CR_STATUS: status <= status_t'(wr_data[1:0]);
        CR_CAUSE:  cause  <= wr_data[2:0];
        CR_EPC:    epc    <= wr_data[WORD_ADDR_W+1:2];
        default:   vector <= wr_data[WORD_ADDR_W+1:2];
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      CR_STATUS: rd_data[1:0]             = status;
      CR_CAUSE:  rd_data[2:0]             = cause;
      CR_EPC:    rd_data[WORD_ADDR_W+1:2] = epc;
      default:   rd_data[WORD_ADDR_W+1:2] = vector;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: prioritises busy/exception/IRQ/ERET/WRCR/load-hazard into stall, flush and redirect.
// Latency: all pipeline outputs combinational in the event cycle; CR and FSM update at the following edge.
// Backpressure: any bus busy stalls every stage and freezes state so the MEM-stage event is retried.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WORD_ADDR_W = 30,
  parameter int WORD_DATA_W = 32,
  parameter logic [WORD_ADDR_W-1:0] VEC_RESET = 30'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   IFBusy,
  input  logic                   MemBusy,
  input  logic                   LoadHazard,
  input  logic                   IRQ,
  input  logic [WORD_ADDR_W-1:0] MemPC,
  input  logic                   MemEn,
  input  logic [1:0]             MemCtrlOp,
  input  logic [4:0]             MemDstAddr,
  input  logic [2:0]             MemExpCode,
  input  logic [WORD_DATA_W-1:0] MemOut,
  input  logic [1:0]             CRAddr,
  output logic [WORD_DATA_W-1:0] CRData,
  output logic                   IFStall,
  output logic                   IDStall,
  output logic                   EXStall,
  output logic                   MemStall,
  output logic                   IFFlush,
  output logic                   IDFlush,
  output logic                   EXFlush,
  output logic                   MemFlush,
  output logic                   PCLoad,
  output logic [WORD_ADDR_W-1:0] NewPC,
  output logic                   GPRKill
);

  ctrl_state_t            state, state_nxt;
  logic                   busy, exp_evt, irq_evt, eret_evt, wrcr_evt;
  logic                   exp_take, eret_take, cr_wr;
  logic [2:0]             exp_code;
  logic                   ie;
  logic [WORD_ADDR_W-1:0] epc, vector;
  logic                   unused_dst;

  assign unused_dst = ^MemDstAddr[4:2];

  assign busy     = IFBusy | MemBusy;
  assign exp_evt  = MemEn && (MemExpCode != EXP_NO_EXP);
  assign irq_evt  = MemEn && IRQ && ie && (state == CTRL_ST_RUN);
  assign eret_evt = MemEn && (MemCtrlOp == CTRL_OP_ERET);
  assign wrcr_evt = MemEn && (MemCtrlOp == CTRL_OP_WRCR);

  always_ff @(posedge clk) begin
    if (reset) state <= CTRL_ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    IFStall   = 1'b0;
    IDStall   = 1'b0;
    EXStall   = 1'b0;
    MemStall  = 1'b0;
    IFFlush   = 1'b0;
    IDFlush   = 1'b0;
    EXFlush   = 1'b0;
    MemFlush  = 1'b0;
    PCLoad    = 1'b0;
    NewPC     = '0;
    GPRKill   = 1'b0;
    exp_take  = 1'b0;
    eret_take = 1'b0;
    cr_wr     = 1'b0;
    exp_code  = exp_evt ? MemExpCode : EXP_EXT_INT;
    state_nxt = CTRL_ST_RUN;
    if (busy) begin
      {IFStall, IDStall, EXStall, MemStall} = 4'hf;
      state_nxt = state;
    end else if (exp_evt || irq_evt) begin
      {IFFlush, IDFlush, EXFlush, MemFlush} = 4'hf;
      PCLoad    = 1'b1;
      NewPC     = vector;
      GPRKill   = 1'b1;
      exp_take  = 1'b1;
      state_nxt = CTRL_ST_REDIRECT;
    end else if (eret_evt) begin
      {IFFlush, IDFlush, EXFlush, MemFlush} = 4'hf;
      PCLoad    = 1'b1;
      NewPC     = epc;
      eret_take = 1'b1;
      state_nxt = CTRL_ST_REDIRECT;
    end else if (wrcr_evt) begin
      cr_wr = 1'b1;
    end else if (LoadHazard) begin
      IFStall = 1'b1;
      IDStall = 1'b1;
      EXFlush = 1'b1;
    end
  end

  pipe_ctrl_cr #(
    .WORD_ADDR_W (WORD_ADDR_W),
    .WORD_DATA_W (WORD_DATA_W),
    .VEC_RESET   (VEC_RESET)
  ) u_cr (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (cr_wr),
    .wr_addr   (MemDstAddr[1:0]),
    .wr_data   (MemOut),
    .exp_take  (exp_take),
    .exp_code  (exp_code),
    .exp_pc    (MemPC),
    .eret_take (eret_take),
    .rd_addr   (CRAddr),
    .rd_data   (CRData),
    .ie        (ie),
    .epc       (epc),
    .vector    (vector)
  );

endmodule
